// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster constants, shared by the timing generator, its
// axis counter and the output interface.
package vga_timing_pkg;

   localparam int DEF_POS_W     = 10;

   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;

   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam bit DEF_SYNC_POL  = 1'b0;

   function automatic int axis_total(input int disp, input int front, input int sync,
                                     input int back);
      return disp + front + sync + back;
   endfunction

   function automatic int sync_start(input int disp, input int front);
      return disp + front;
   endfunction

   function automatic int sync_end(input int disp, input int front, input int sync);
      return disp + front + sync;
   endfunction

   localparam int DEF_H_TOTAL      = axis_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
   localparam int DEF_V_TOTAL      = axis_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
   localparam int DEF_H_SYNC_START = sync_start(DEF_H_DISPLAY, DEF_H_FRONT);
   localparam int DEF_H_SYNC_END   = sync_end(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC);
   localparam int DEF_V_SYNC_START = sync_start(DEF_V_DISPLAY, DEF_V_FRONT);
   localparam int DEF_V_SYNC_END   = sync_end(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator (master) to the renderer (slave).
interface vga_timing_gen_if
   import vga_timing_pkg::*;
#(
   parameter int POS_W = DEF_POS_W
);
   logic [POS_W-1:0] hpos;
   logic [POS_W-1:0] vpos;
   logic             display_on;
   logic             hsync;
   logic             vsync;
   logic             line_tick;
   logic             frame_tick;
   logic [7:0]       frame_count;

   modport master (
      output hpos, vpos, display_on, hsync, vsync, line_tick, frame_tick, frame_count
   );

   modport slave (
      input  hpos, vpos, display_on, hsync, vsync, line_tick, frame_tick, frame_count
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with display and sync window decode
// taken from the next count, so the flags line up with the registered count.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int W = DEF_POS_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic [W-1:0] wrap_val_i,
   input  logic [W-1:0] disp_end_i,
   input  logic [W-1:0] sync_start_i,
   input  logic [W-1:0] sync_end_i,
   input  logic         sync_pol_i,
   output logic [W-1:0] count_o,
   output logic         in_display_o,
   output logic         sync_o,
   output logic         wrap_o
);

   logic [W-1:0] count_q, count_d;
   logic         in_display_q, in_display_d;
   logic         sync_q, sync_d;

   assign wrap_o = en_i && (count_q == wrap_val_i);

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = (count_q == wrap_val_i) ? '0 : count_q + 1'b1;
      end
      in_display_d = (count_d < disp_end_i);
      sync_d       = ((count_d >= sync_start_i) && (count_d < sync_end_i)) ? sync_pol_i
                                                                           : ~sync_pol_i;
   end

   // Reset parks the counter on its last position so the first enabled edge lands on 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q      <= wrap_val_i;
         in_display_q <= 1'b0;
         sync_q       <= ~sync_pol_i;
      end else begin
         count_q      <= count_d;
         in_display_q <= in_display_d;
         sync_q       <= sync_d;
      end
   end

   assign count_o      = count_q;
   assign in_display_o = in_display_q;
   assign sync_o       = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster timing generator; all outputs describe the same pixel.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY = DEF_H_DISPLAY,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_DISPLAY = DEF_V_DISPLAY,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter bit SYNC_POL  = DEF_SYNC_POL,
   parameter int POS_W     = DEF_POS_W
) (
   input  logic             clk,
   input  logic             rst_n,
   vga_timing_gen_if.master vga_o
);

   localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

   localparam logic [POS_W-1:0] H_WRAP     = POS_W'(H_TOTAL - 1);
   localparam logic [POS_W-1:0] V_WRAP     = POS_W'(V_TOTAL - 1);
   localparam logic [POS_W-1:0] H_DISP_END = POS_W'(H_DISPLAY);
   localparam logic [POS_W-1:0] V_DISP_END = POS_W'(V_DISPLAY);
   localparam logic [POS_W-1:0] H_SYNC_S   = POS_W'(sync_start(H_DISPLAY, H_FRONT));
   localparam logic [POS_W-1:0] H_SYNC_E   = POS_W'(sync_end(H_DISPLAY, H_FRONT, H_SYNC));
   localparam logic [POS_W-1:0] V_SYNC_S   = POS_W'(sync_start(V_DISPLAY, V_FRONT));
   localparam logic [POS_W-1:0] V_SYNC_E   = POS_W'(sync_end(V_DISPLAY, V_FRONT, V_SYNC));

   if ((H_TOTAL > (1 << POS_W)) || (V_TOTAL > (1 << POS_W))) begin : g_size_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in POS_W bits");
   end

   logic [POS_W-1:0] h_count, v_count;
   logic             h_disp, v_disp, h_sync, v_sync, h_wrap, v_wrap;
   logic             line_tick_q, line_tick_d;
   logic             frame_tick_q, frame_tick_d;

   vga_axis_counter #(.W(POS_W)) u_h_axis (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (1'b1),
      .wrap_val_i   (H_WRAP),
      .disp_end_i   (H_DISP_END),
      .sync_start_i (H_SYNC_S),
      .sync_end_i   (H_SYNC_E),
      .sync_pol_i   (SYNC_POL),
      .count_o      (h_count),
      .in_display_o (h_disp),
      .sync_o       (h_sync),
      .wrap_o       (h_wrap)
   );

   vga_axis_counter #(.W(POS_W)) u_v_axis (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (h_wrap),
      .wrap_val_i   (V_WRAP),
      .disp_end_i   (V_DISP_END),
      .sync_start_i (V_SYNC_S),
      .sync_end_i   (V_SYNC_E),
      .sync_pol_i   (SYNC_POL),
      .count_o      (v_count),
      .in_display_o (v_disp),
      .sync_o       (v_sync),
      .wrap_o       (v_wrap)
   );

   // A wrap now means the next registered position is column 0 (and line 0).
   assign line_tick_d  = h_wrap;
   assign frame_tick_d = h_wrap & v_wrap;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         line_tick_q  <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         line_tick_q  <= line_tick_d;
         frame_tick_q <= frame_tick_d;
      end
   end

`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [7:0] frame_count_q, frame_count_d;

   assign frame_count_d = frame_tick_d ? frame_count_q + 8'd1 : frame_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_count_q <= 8'd0;
      end else begin
         frame_count_q <= frame_count_d;
      end
   end

   assign vga_o.frame_count = frame_count_q;
`else
   assign vga_o.frame_count = 8'd0;
`endif

   assign vga_o.hpos       = h_count;
   assign vga_o.vpos       = v_count;
   assign vga_o.display_on = h_disp & v_disp;
   assign vga_o.hsync      = h_sync;
   assign vga_o.vsync      = v_sync;
   assign vga_o.line_tick  = line_tick_q;
   assign vga_o.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size, tall (real vertical) and tiny rasters checked
// every cycle against an arithmetic model of the raster position.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_COUNT_EN
   localparam bit FC_EN = 1'b1;
`else
   localparam bit FC_EN = 1'b0;
`endif

   typedef struct {
      int hd, hf, hs, hb, vd, vf, vs, vb;
   } tim_t;

   typedef struct packed {
      logic [31:0] hpos;
      logic [31:0] vpos;
      logic [31:0] fc;
      logic        de, hs, vs, lt, ft;
   } out_t;

   typedef struct {
      bit   rst_n;
      int   n;
      out_t exp;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_full = 1'b0, rst_tall = 1'b0, rst_tiny = 1'b0;
   int   n_vec = 0, n_err = 0;

   tim_t tm_full = '{640, 16, 96, 48, 480, 10, 2, 33};
   tim_t tm_tall = '{4, 1, 2, 1, 480, 10, 2, 33};
   tim_t tm_tiny = '{4, 1, 2, 1, 3, 1, 1, 1};

   vga_timing_gen_if vga_full ();
   vga_timing_gen_if vga_tall ();
   vga_timing_gen_if vga_tiny ();

   vga_timing_gen u_full (.clk(clk), .rst_n(rst_full), .vga_o(vga_full));

   vga_timing_gen #(.H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1)) u_tall (
      .clk(clk), .rst_n(rst_tall), .vga_o(vga_tall));

   vga_timing_gen #(.H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_tiny (
      .clk(clk), .rst_n(rst_tiny), .vga_o(vga_tiny));

   // Position is pure arithmetic on clocks elapsed since reset release (t = 0 on first edge).
   function automatic out_t model(input tim_t tm, input longint t);
      out_t   e;
      int     ht, vt, h, v;
      longint ln;
      ht = tm.hd + tm.hf + tm.hs + tm.hb;
      vt = tm.vd + tm.vf + tm.vs + tm.vb;
      if (t < 0) begin
         e = '{32'(ht - 1), 32'(vt - 1), 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      end else begin
         h  = int'(t % ht);
         ln = t / ht;
         v  = int'(ln % vt);
         e.hpos = 32'(h);
         e.vpos = 32'(v);
         e.de   = (h < tm.hd) && (v < tm.vd);
         e.hs   = !((h >= tm.hd + tm.hf) && (h < tm.hd + tm.hf + tm.hs));
         e.vs   = !((v >= tm.vd + tm.vf) && (v < tm.vd + tm.vf + tm.vs));
         e.lt   = (h == 0);
         e.ft   = (h == 0) && (v == 0);
         e.fc   = FC_EN ? 32'((ln / vt + 1) % 256) : 32'd0;
      end
      return e;
   endfunction

   function automatic out_t pack_out(input logic [9:0] hp, input logic [9:0] vp,
                                     input logic de, input logic hs, input logic vs,
                                     input logic lt, input logic ft, input logic [7:0] fc);
      out_t a;
      a = '{{22'd0, hp}, {22'd0, vp}, {24'd0, fc}, de, hs, vs, lt, ft};
      return a;
   endfunction

   task automatic cmp(input string nm, input out_t got, input out_t exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got h=%0d v=%0d de=%b hs=%b vs=%b lt=%b ft=%b fc=%0d, expected h=%0d v=%0d de=%b hs=%b vs=%b lt=%b ft=%b fc=%0d",
                  nm, got.hpos, got.vpos, got.de, got.hs, got.vs, got.lt, got.ft, got.fc,
                  exp.hpos, exp.vpos, exp.de, exp.hs, exp.vs, exp.lt, exp.ft, exp.fc);
      end
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   function automatic out_t act_full();
      return pack_out(vga_full.hpos, vga_full.vpos, vga_full.display_on, vga_full.hsync,
                      vga_full.vsync, vga_full.line_tick, vga_full.frame_tick, vga_full.frame_count);
   endfunction
   function automatic out_t act_tall();
      return pack_out(vga_tall.hpos, vga_tall.vpos, vga_tall.display_on, vga_tall.hsync,
                      vga_tall.vsync, vga_tall.line_tick, vga_tall.frame_tick, vga_tall.frame_count);
   endfunction
   function automatic out_t act_tiny();
      return pack_out(vga_tiny.hpos, vga_tiny.vpos, vga_tiny.display_on, vga_tiny.hsync,
                      vga_tiny.vsync, vga_tiny.line_tick, vga_tiny.frame_tick, vga_tiny.frame_count);
   endfunction

   // -2: no reset seen yet, -1: last edge was in reset.
   longint t_full = -2, t_tall = -2, t_tiny = -2;

   always @(posedge clk) begin
      t_full = !rst_full ? -1 : ((t_full == -2) ? -2 : t_full + 1);
      t_tall = !rst_tall ? -1 : ((t_tall == -2) ? -2 : t_tall + 1);
      t_tiny = !rst_tiny ? -1 : ((t_tiny == -2) ? -2 : t_tiny + 1);
   end

   always @(negedge clk) begin
      if (t_full != -2) cmp("model_full", act_full(), model(tm_full, t_full));
      if (t_tall != -2) cmp("model_tall", act_tall(), model(tm_tall, t_tall));
      if (t_tiny != -2) cmp("model_tiny", act_tiny(), model(tm_tiny, t_tiny));
   end

   vec_t tbl[12];

   initial begin
      out_t e;
      int   cyc, vs_low, n, len, sel;
      bit   seen;

      tbl[0]  = '{1'b0, 3,   '{32'd799, 32'd524, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[1]  = '{1'b1, 1,   '{32'd0,   32'd0,   32'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}};
      tbl[2]  = '{1'b1, 639, '{32'd639, 32'd0,   32'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[3]  = '{1'b1, 1,   '{32'd640, 32'd0,   32'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[4]  = '{1'b1, 16,  '{32'd656, 32'd0,   32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
      tbl[5]  = '{1'b1, 95,  '{32'd751, 32'd0,   32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
      tbl[6]  = '{1'b1, 1,   '{32'd752, 32'd0,   32'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[7]  = '{1'b1, 47,  '{32'd799, 32'd0,   32'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[8]  = '{1'b1, 1,   '{32'd0,   32'd1,   32'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}};
      tbl[9]  = '{1'b1, 300, '{32'd300, 32'd1,   32'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[10] = '{1'b0, 1,   '{32'd799, 32'd524, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[11] = '{1'b1, 1,   '{32'd0,   32'd0,   32'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}};

      for (int i = 0; i < 12; i++) begin
         rst_full = tbl[i].rst_n;
         repeat (tbl[i].n) @(posedge clk);
         #1;
         e = tbl[i].exp;
         e.fc = FC_EN ? e.fc : 32'd0;
         cmp($sformatf("table[%0d]", i), act_full(), e);
      end

      // Random reset pulses on the small rasters.
      rst_tall = 1'b1;
      rst_tiny = 1'b1;
      for (int k = 0; k < 8; k++) begin
         n   = int'($urandom_range(3000, 20));
         len = int'($urandom_range(3, 1));
         sel = int'($urandom_range(2, 0));
         repeat (n) @(posedge clk);
         #1;
         if (sel != 1) rst_tiny = 1'b0;
         if (sel != 0) rst_tall = 1'b0;
         repeat (len) @(posedge clk);
         #1;
         rst_tiny = 1'b1;
         rst_tall = 1'b1;
      end

      // Mid-frame reset on the tall raster at line 200.
      cyc = 0;
      while (!(vga_tall.vpos == 10'd200 && vga_tall.hpos == 10'd3) && cyc < 5000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("midframe_reach", cyc < 5000 ? 1 : 0, 1);
      rst_tall = 1'b0;
      @(posedge clk);
      #1;
      rst_tall = 1'b1;
      cmp("midframe_reset", act_tall(), '{32'd7, 32'd524, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      cmp("midframe_restart", act_tall(),
          '{32'd0, 32'd0, FC_EN ? 32'd1 : 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});

      // Frame period and vsync width on the tall raster (8 clocks per line).
      cyc    = 0;
      vs_low = 0;
      seen   = 1'b0;
      while (!seen && cyc < 5000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (vga_tall.vsync == 1'b0) vs_low++;
         seen = vga_tall.frame_tick;
      end
      chk("frame_period_tall", seen ? cyc : -1, 525 * 8);
      chk("vsync_width_tall", vs_low, 2 * 8);

      // frame_count sequence over 257 frames on the tiny raster.
      rst_tiny = 1'b0;
      @(posedge clk);
      #1;
      rst_tiny = 1'b1;
      for (int k = 0; k < 257; k++) begin
         cyc  = 0;
         seen = 1'b0;
         while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = vga_tiny.frame_tick;
         end
         if (!seen) begin
            chk("frame_tick_timeout", 0, 1);
            break;
         end
         if (k < 3 || k > 253) begin
            chk($sformatf("frame_count[%0d]", k), int'(vga_tiny.frame_count),
                FC_EN ? (k + 1) % 256 : 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
